// File: rtl/fir_decim_avg.sv
// fir_decim_avg: integrate-and-dump decimator with round/shift/saturate into a small valid/ready FIFO.
// Ports: clk, rst (sync active-high), clr (window + overflow clear), in_valid/in_data (signed samples, never stalled),
//        out_valid/out_ready/out_data (FIFO head), level (occupancy), overflow (sticky dropped-result flag).
module fir_decim_avg #(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 9,
  parameter int DECIM     = 4,
  parameter int SHIFT     = 2,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow
);
  localparam int ACC_W = IN_WIDTH + $clog2(DECIM);
  localparam int SW = ACC_W + 1;
  localparam int XW = (SW > OUT_WIDTH ? SW : OUT_WIDTH) + 1;
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [SW-1:0] RND = SHIFT > 0 ? SW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  localparam logic signed [XW-1:0] SMAX = XW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] SMIN = -SMAX - XW'(1);
  logic signed [ACC_W-1:0] acc;
  logic [PW-1:0] phase;
  logic signed [SW-1:0] sum, rounded;
  logic signed [XW-1:0] wide;
  logic signed [OUT_WIDTH-1:0] result;
  logic signed [OUT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic dump, pop, full, push, drop;
  always_comb begin
    dump = in_valid & ~clr & (phase == PW'(DECIM - 1));
    sum = SW'(acc) + SW'(in_data);
    rounded = (sum + RND) >>> SHIFT;
    wide = XW'(rounded);
    result = wide > SMAX ? SMAX[OUT_WIDTH-1:0] : wide < SMIN ? SMIN[OUT_WIDTH-1:0] : wide[OUT_WIDTH-1:0];
    out_valid = level != '0;
    out_data = mem[rd_ptr];
    pop = out_valid & out_ready;
    full = level == (AW+1)'(DEPTH);
    // a full FIFO still takes the new result when the head leaves in the same cycle
    push = dump & (~full | pop);
    drop = dump & full & ~pop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      phase <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (clr) begin
        acc <= '0;
        phase <= '0;
        overflow <= 1'b0;
      end else if (in_valid) begin
        acc <= dump ? '0 : acc + ACC_W'(in_data);
        phase <= dump ? '0 : phase + 1'b1;
      end
      if (push) begin
        mem[wr_ptr] <= result;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_decim_avg.sv
// tb_fir_decim_avg: directed table-driven bench for fir_decim_avg (default build plus a SHIFT=0 build).
module tb_fir_decim_avg;
  typedef struct {
    logic r, c, v;
    logic signed [8:0] d;
    logic rdy, ev;
    logic signed [8:0] ed;
    logic [2:0] el;
    logic eo;
  } vec_t;
  logic clk = 0, rst = 1, clr = 0, in_valid = 0, out_ready = 0;
  logic signed [8:0] in_data = 0;
  logic v0, v1, o0, o1;
  logic signed [8:0] d0, d1;
  logic [2:0] l0, l1;
  int n = 0, fails = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  fir_decim_avg u0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .level(l0), .overflow(o0)
  );
  fir_decim_avg #(.SHIFT(0)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .level(l1), .overflow(o1)
  );
  task automatic apply(input logic r, c, v, input logic signed [8:0] d, input logic rdy);
    rst = r;
    clr = c;
    in_valid = v;
    in_data = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic av, input logic signed [8:0] ad, input logic [2:0] al, input logic ao,
                     input logic ev, input logic signed [8:0] ed, input logic [2:0] el, input logic eo);
    n++;
    if (av !== ev || (ev && ad !== ed) || al !== el || ao !== eo) begin
      fails++;
      $display("FAIL %s: got valid=%0b data=%0d level=%0d ovf=%0b, want valid=%0b data=%0d level=%0d ovf=%0b",
               nm, av, ad, al, ao, ev, ed, el, eo);
    end
  endtask
  task automatic add(input logic r, c, v, input logic signed [8:0] d, input logic rdy,
                     input logic ev, input logic signed [8:0] ed, input logic [2:0] el, input logic eo);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.d = d; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.el = el; t.eo = eo;
    tbl.push_back(t);
  endtask
  initial begin
    // basic window average, back-to-back samples
    add(0,0,1,10,1, 0,0,0,0); add(0,0,1,20,1, 0,0,0,0); add(0,0,1,30,1, 0,0,0,0);
    add(0,0,1,41,1, 1,25,1,0); add(0,0,0,0,1, 0,0,0,0);
    // negative samples with idle gaps 0,3,1
    add(0,0,1,-1,1, 0,0,0,0); add(0,0,1,-2,1, 0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0,1, 0,0,0,0);
    add(0,0,1,-3,1, 0,0,0,0); add(0,0,0,0,1, 0,0,0,0);
    add(0,0,1,-4,1, 1,-2,1,0); add(0,0,0,0,1, 0,0,0,0);
    // five windows into a stalled FIFO: fifth result dropped
    for (int w = 0; w < 5; w++)
      for (int s = 0; s < 4; s++)
        add(0,0,1,8,0, w > 0 || s == 3, 8, 3'((s == 3) ? ((w < 4) ? w + 1 : 4) : w), (w == 4) && (s == 3));
    for (int k = 0; k < 4; k++) add(0,0,0,0,1, k < 3, 8, 3'(3 - k), 1);
    add(0,0,0,0,0, 0,0,0,1);
    add(0,1,0,0,0, 0,0,0,0);
    // refill to full, then dump with a simultaneous pop
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < 4; s++)
        add(0,0,1,9'(4 * (w + 1)),0, w > 0 || s == 3, 4, 3'((s == 3) ? w + 1 : w), 0);
    for (int s = 0; s < 3; s++) add(0,0,1,20,0, 1,4,4,0);
    add(0,0,1,20,1, 1,8,4,0);
    add(0,0,0,0,1, 1,12,3,0); add(0,0,0,0,1, 1,16,2,0);
    add(0,0,0,0,1, 1,20,1,0); add(0,0,0,0,1, 0,0,0,0);
    // reset mid-window discards the partial sum
    add(0,0,1,100,1, 0,0,0,0); add(0,0,1,100,1, 0,0,0,0);
    add(1,0,1,100,1, 0,0,0,0);
    add(0,0,1,4,0, 0,0,0,0); add(0,0,1,8,0, 0,0,0,0); add(0,0,1,12,0, 0,0,0,0);
    add(0,0,1,16,0, 1,10,1,0);
    // clr mid-window discards the partial sum and its own sample but keeps the FIFO
    add(0,0,1,100,0, 1,10,1,0); add(0,0,1,100,0, 1,10,1,0);
    add(0,1,1,100,0, 1,10,1,0);
    add(0,0,1,4,0, 1,10,1,0); add(0,0,1,8,0, 1,10,1,0); add(0,0,1,12,0, 1,10,1,0);
    add(0,0,1,16,0, 1,10,2,0);
    add(0,0,0,0,1, 1,10,1,0); add(0,0,0,0,1, 0,0,0,0);

    apply(1,0,0,0,0);
    n++;
    if (v0 !== 0 || d0 !== 0 || l0 !== 0 || o0 !== 0) begin
      fails++;
      $display("FAIL reset: got valid=%0b data=%0d level=%0d ovf=%0b, want all 0", v0, d0, l0, o0);
    end
    // saturation: SHIFT=0 build clips, default build averages
    for (int i = 0; i < 4; i++) apply(0,0,1,255,1);
    chk("sat_pos_s0", v1, d1, l1, o1, 1, 255, 1, 0);
    chk("avg_pos_s2", v0, d0, l0, o0, 1, 255, 1, 0);
    apply(0,0,0,0,1);
    chk("sat_pos_pop", v1, d1, l1, o1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply(0,0,1,-256,1);
    chk("sat_neg_s0", v1, d1, l1, o1, 1, -256, 1, 0);
    chk("avg_neg_s2", v0, d0, l0, o0, 1, -256, 1, 0);
    apply(0,0,0,0,1);
    chk("sat_neg_pop", v0, d0, l0, o0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].rdy);
      chk($sformatf("vec%0d", i), v0, d0, l0, o0, tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].eo);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
